// File: rtl/hazard_fwd_unit_pkg.sv
// Shared LC-3b pipeline types for the hazard/forwarding unit.
// Default-width entry layout, forward-select encodings and a saturating counter helper.
package hazard_fwd_unit_pkg;

  typedef logic [2:0] lc3b_reg;

  typedef struct packed {
    logic          valid;
    lc3b_reg       dest;
    logic          we;
    logic          is_load;
    lc3b_reg [1:0] src;
    logic    [1:0] src_used;
  } hazard_entry_t;

  localparam int unsigned FWD_REGFILE = 0;
  localparam int unsigned FWD_MEM     = 1;
  localparam int unsigned FWD_WB      = 2;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// ID-side control bundle of the hazard/forwarding unit.
// Defining HAZARD_STATS_EN adds stats_clr and the three event counters.
interface hazard_fwd_unit_if #(
  parameter int unsigned REG_W   = 3,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned STAGES  = 3,
  parameter int unsigned SEL_W   = $clog2(STAGES)
);
  logic                     id_valid;
  logic [NUM_SRC*REG_W-1:0] id_src;
  logic [NUM_SRC-1:0]       id_src_used;
  logic [REG_W-1:0]         id_dest;
  logic                     id_dest_we;
  logic                     id_is_load;
  logic                     mem_stall;
  logic                     flush;
  logic                     id_stall;
  logic                     issue_bubble;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     ex_valid;
`ifdef HAZARD_STATS_EN
  logic                     stats_clr;
  logic [31:0]              stall_cnt;
  logic [31:0]              flush_cnt;
  logic [31:0]              mstall_cnt;

  modport master (
    output id_valid, id_src, id_src_used, id_dest, id_dest_we, id_is_load, mem_stall, flush,
           stats_clr,
    input  id_stall, issue_bubble, fwd_sel, ex_valid, stall_cnt, flush_cnt, mstall_cnt
  );
  modport slave (
    input  id_valid, id_src, id_src_used, id_dest, id_dest_we, id_is_load, mem_stall, flush,
           stats_clr,
    output id_stall, issue_bubble, fwd_sel, ex_valid, stall_cnt, flush_cnt, mstall_cnt
  );
`else
  modport master (
    output id_valid, id_src, id_src_used, id_dest, id_dest_we, id_is_load, mem_stall, flush,
    input  id_stall, issue_bubble, fwd_sel, ex_valid
  );
  modport slave (
    input  id_valid, id_src, id_src_used, id_dest, id_dest_we, id_is_load, mem_stall, flush,
    output id_stall, issue_bubble, fwd_sel, ex_valid
  );
`endif
endinterface

// File: rtl/hazard_fwd_unit_fwd_match.sv
// Priority comparator for one EX source against the older tracked stages.
// Returns the youngest stage index writing the source register, or 0 for the regfile.
module fwd_match #(
  parameter int unsigned REG_W  = 3,
  parameter int unsigned STAGES = 3,
  parameter int unsigned SEL_W  = $clog2(STAGES)
) (
  input  logic                          i_en,
  input  logic [REG_W-1:0]              i_src,
  input  logic [(STAGES-1)*REG_W-1:0]   i_dest,
  input  logic [STAGES-2:0]             i_wr,
  output logic [SEL_W-1:0]              o_sel
);

  // Walk oldest to youngest so the youngest match overwrites.
  always_comb begin
    o_sel = '0;
    for (int k = STAGES - 1; k >= 1; k--) begin
      if (i_en && i_wr[k-1] && (i_dest[(k-1)*REG_W +: REG_W] == i_src)) begin
        o_sel = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Scoreboard-based hazard and forwarding controller for the LC-3b pipeline.
// Optional HAZARD_STATS_EN adds saturating stall/flush/mem-stall event counters.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int unsigned REG_W       = 3,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned STAGES      = 3,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned SEL_W       = $clog2(STAGES)
) (
  input logic               clk,
  input logic               reset,
  hazard_fwd_unit_if.slave  io_bus
);

  typedef struct packed {
    logic                     valid;
    logic [REG_W-1:0]         dest;
    logic                     we;
    logic                     is_load;
    logic [NUM_SRC*REG_W-1:0] src;
    logic [NUM_SRC-1:0]       src_used;
  } entry_t;

  entry_t [STAGES-1:0]         r_ent;
  entry_t [STAGES-1:0]         w_ent_nxt;
  entry_t                      w_id_ent;
  logic                        w_src_hit;
  logic                        w_hazard;
  logic [NUM_SRC*SEL_W-1:0]    w_fwd_sel;
  logic [(STAGES-1)*REG_W-1:0] w_old_dest;
  logic [STAGES-2:0]           w_old_wr;
  logic                        w_ld_fwd;
  logic                        w_unused_fields;

  always_comb begin
    w_id_ent          = '0;
    w_id_ent.valid    = io_bus.id_valid;
    w_id_ent.dest     = io_bus.id_dest;
    w_id_ent.we       = io_bus.id_dest_we;
    w_id_ent.is_load  = io_bus.id_is_load;
    w_id_ent.src      = io_bus.id_src;
    w_id_ent.src_used = io_bus.id_src_used;
  end

  always_comb begin
    w_src_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (io_bus.id_src_used[i] && (io_bus.id_src[i*REG_W +: REG_W] == r_ent[0].dest)) begin
        w_src_hit = 1'b1;
      end
    end
  end

  assign w_hazard = io_bus.id_valid & r_ent[0].valid & r_ent[0].we & r_ent[0].is_load & w_src_hit;

  // Flush squashes every entry sourced from a stage younger than the branch.
  always_comb begin
    w_ent_nxt = r_ent;
    if (!io_bus.mem_stall) begin
      for (int unsigned k = 1; k < STAGES; k++) begin
        w_ent_nxt[k] = (io_bus.flush && (k <= FLUSH_DEPTH)) ? '0 : r_ent[k-1];
      end
      w_ent_nxt[0] = (io_bus.flush || w_hazard) ? '0 : w_id_ent;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ent <= '0;
    end else begin
      r_ent <= w_ent_nxt;
    end
  end

  for (genvar k = 1; k < STAGES; k++) begin : g_old
    assign w_old_dest[(k-1)*REG_W +: REG_W] = r_ent[k].dest;
    assign w_old_wr[k-1]                    = r_ent[k].valid & r_ent[k].we;
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(
      .REG_W  (REG_W),
      .STAGES (STAGES),
      .SEL_W  (SEL_W)
    ) u_fwd_match (
      .i_en   (r_ent[0].valid & r_ent[0].src_used[i]),
      .i_src  (r_ent[0].src[i*REG_W +: REG_W]),
      .i_dest (w_old_dest),
      .i_wr   (w_old_wr),
      .o_sel  (w_fwd_sel[i*SEL_W +: SEL_W])
    );
  end

  assign io_bus.fwd_sel      = w_fwd_sel;
  assign io_bus.ex_valid     = r_ent[0].valid;
  assign io_bus.id_stall     = ~reset & (io_bus.mem_stall | (w_hazard & ~io_bus.flush));
  assign io_bus.issue_bubble = ~reset & ~io_bus.mem_stall &
                               (io_bus.flush | w_hazard | ~io_bus.id_valid);

  always_comb begin
    w_ld_fwd        = 1'b0;
    w_unused_fields = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (w_fwd_sel[i*SEL_W +: SEL_W] == SEL_W'(1)) w_ld_fwd = 1'b1;
    end
    for (int unsigned k = 1; k < STAGES; k++) begin
      w_unused_fields = w_unused_fields ^ (^{r_ent[k].is_load, r_ent[k].src, r_ent[k].src_used});
    end
  end

  // The load-use stall must keep a load result from ever being needed out of MEM.
  a_no_mem_load_fwd : assert property (@(posedge clk) disable iff (reset)
    !(w_ld_fwd && r_ent[1].is_load))
    else $error("load result selected for forwarding from MEM stage");

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic [31:0] r_mstall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_mstall_cnt <= '0;
    end else if (io_bus.stats_clr) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_mstall_cnt <= '0;
    end else begin
      if (w_hazard && !io_bus.flush && !io_bus.mem_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (io_bus.flush && !io_bus.mem_stall) r_flush_cnt <= sat_inc(r_flush_cnt);
      if (io_bus.mem_stall) r_mstall_cnt <= sat_inc(r_mstall_cnt);
    end
  end

  assign io_bus.stall_cnt  = r_stall_cnt;
  assign io_bus.flush_cnt  = r_flush_cnt;
  assign io_bus.mstall_cnt = r_mstall_cnt;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed pipeline scenarios then random traffic,
// all compared against an instruction-level pipeline model (HAZARD_STATS_EN adds counters).
module tb_hazard_fwd_unit;
  import hazard_fwd_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.REG_W(3), .NUM_SRC(2), .STAGES(3)) bus ();

  hazard_fwd_unit #(
    .REG_W       (3),
    .NUM_SRC     (2),
    .STAGES      (3),
    .FLUSH_DEPTH (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  hazard_entry_t [2:0] pipe;
  logic [31:0] m_stall_cnt, m_flush_cnt, m_mstall_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input lc3b_reg s1, input lc3b_reg s0,
                        input logic [1:0] used, input lc3b_reg d, input logic we,
                        input logic ld);
    bus.id_valid    = v;
    bus.id_src      = {s1, s0};
    bus.id_src_used = used;
    bus.id_dest     = d;
    bus.id_dest_we  = we;
    bus.id_is_load  = ld;
  endtask

  function automatic hazard_entry_t id_entry();
    hazard_entry_t e;
    e.valid    = bus.id_valid;
    e.dest     = bus.id_dest;
    e.we       = bus.id_dest_we;
    e.is_load  = bus.id_is_load;
    e.src      = bus.id_src;
    e.src_used = bus.id_src_used;
    return e;
  endfunction

  // ID reads a register that the load currently in EX has not produced yet.
  function automatic logic m_hazard();
    logic reads = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (bus.id_src_used[i] && bus.id_src[i*3 +: 3] == pipe[0].dest) reads = 1'b1;
    end
    return bus.id_valid && pipe[0].valid && pipe[0].we && pipe[0].is_load && reads;
  endfunction

  // Youngest in-flight producer of each EX source.
  function automatic logic [3:0] m_fwd();
    logic [3:0] r = '0;
    for (int i = 0; i < 2; i++) begin
      logic found = 1'b0;
      if (pipe[0].valid && pipe[0].src_used[i]) begin
        for (int k = 1; k <= 2; k++) begin
          if (!found && pipe[k].valid && pipe[k].we && pipe[k].dest == pipe[0].src[i]) begin
            r[i*2 +: 2] = 2'(k);
            found = 1'b1;
          end
        end
      end
    end
    return r;
  endfunction

  task automatic check_cycle();
    logic hz;
    #4;
    hz = m_hazard();
    chk("id_stall", 32'(bus.id_stall), 32'(bus.mem_stall || (hz && !bus.flush)));
    chk("issue_bubble", 32'(bus.issue_bubble),
        32'(!bus.mem_stall && (bus.flush || hz || !bus.id_valid)));
    chk("fwd_sel", 32'(bus.fwd_sel), 32'(m_fwd()));
    chk("ex_valid", 32'(bus.ex_valid), 32'(pipe[0].valid));
`ifdef HAZARD_STATS_EN
    chk("stall_cnt", bus.stall_cnt, m_stall_cnt);
    chk("flush_cnt", bus.flush_cnt, m_flush_cnt);
    chk("mstall_cnt", bus.mstall_cnt, m_mstall_cnt);
`endif
  endtask

  task automatic advance();
    hazard_entry_t [2:0] nx = pipe;
    logic hz = m_hazard();
    if (!bus.mem_stall) begin
      nx[2] = pipe[1];
      nx[1] = bus.flush ? '0 : pipe[0];
      nx[0] = (bus.flush || hz) ? '0 : id_entry();
    end
`ifdef HAZARD_STATS_EN
    if (bus.stats_clr) begin
      m_stall_cnt = 0; m_flush_cnt = 0; m_mstall_cnt = 0;
    end else begin
      if (hz && !bus.flush && !bus.mem_stall) m_stall_cnt++;
      if (bus.flush && !bus.mem_stall) m_flush_cnt++;
      if (bus.mem_stall) m_mstall_cnt++;
    end
`endif
    @(posedge clk);
    pipe = nx;
    #1;
  endtask

  task automatic cyc();
    check_cycle();
    advance();
  endtask

  task automatic idle(input int n);
    set_id(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic model_reset();
    pipe = '0;
    m_stall_cnt = 0; m_flush_cnt = 0; m_mstall_cnt = 0;
  endtask

  initial begin
    logic hold;
    reset = 1'b1;
    bus.mem_stall = 1'b1;
    bus.flush = 1'b0;
`ifdef HAZARD_STATS_EN
    bus.stats_clr = 1'b0;
`endif
    set_id(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
    model_reset();
    #2;
    chk("rst_stall", 32'(bus.id_stall), 32'd0);
    chk("rst_bubble", 32'(bus.issue_bubble), 32'd0);
    chk("rst_fwd", 32'(bus.fwd_sel), 32'd0);
    chk("rst_exv", 32'(bus.ex_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.mem_stall = 1'b0;

    // Back-to-back dependency forwards from MEM
    set_id(1'b1, 3'd6, 3'd5, 2'b11, 3'd1, 1'b1, 1'b0); cyc();
    set_id(1'b1, 3'd1, 3'd1, 2'b11, 3'd2, 1'b1, 1'b0); cyc();
    set_id(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
    check_cycle();
    chk("fwd_mem_pair", 32'(bus.fwd_sel), 32'({2'(FWD_MEM), 2'(FWD_MEM)}));
    chk("fwd_mem_nostall", 32'(bus.id_stall), 32'd0);
    advance();
    idle(3);

    // One independent instruction in between forwards from WB
    set_id(1'b1, 3'd6, 3'd5, 2'b11, 3'd1, 1'b1, 1'b0); cyc();
    set_id(1'b1, 3'd7, 3'd6, 2'b11, 3'd5, 1'b1, 1'b0); cyc();
    set_id(1'b1, 3'd1, 3'd1, 2'b11, 3'd2, 1'b1, 1'b0); cyc();
    set_id(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
    check_cycle();
    chk("fwd_wb_pair", 32'(bus.fwd_sel), 32'({2'(FWD_WB), 2'(FWD_WB)}));
    advance();
    idle(3);

    // Load-use: exactly one stall/bubble cycle, then WB forwarding
    set_id(1'b1, 3'd0, 3'd6, 2'b01, 3'd3, 1'b1, 1'b1); cyc();
    set_id(1'b1, 3'd0, 3'd3, 2'b11, 3'd4, 1'b1, 1'b0);
    check_cycle();
    chk("lu_stall", 32'(bus.id_stall), 32'd1);
    chk("lu_bubble", 32'(bus.issue_bubble), 32'd1);
    advance();
    check_cycle();
    chk("lu_stall_released", 32'(bus.id_stall), 32'd0);
    chk("lu_bubble_released", 32'(bus.issue_bubble), 32'd0);
    advance();
    set_id(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
    check_cycle();
    chk("lu_fwd", 32'(bus.fwd_sel), 32'({2'(FWD_REGFILE), 2'(FWD_WB)}));
    chk("lu_exv", 32'(bus.ex_valid), 32'd1);
    advance();
    idle(3);

    // Load-use coinciding with flush: flush wins
    set_id(1'b1, 3'd0, 3'd6, 2'b01, 3'd3, 1'b1, 1'b1); cyc();
    set_id(1'b1, 3'd0, 3'd3, 2'b11, 3'd4, 1'b1, 1'b0);
    bus.flush = 1'b1;
    check_cycle();
    chk("fl_stall", 32'(bus.id_stall), 32'd0);
    chk("fl_bubble", 32'(bus.issue_bubble), 32'd1);
    advance();
    bus.flush = 1'b0;
    set_id(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
    check_cycle();
    chk("fl_exv", 32'(bus.ex_valid), 32'd0);
    chk("fl_fwd", 32'(bus.fwd_sel), 32'd0);
    advance();
    idle(3);

    // Four mem-stall cycles freeze the dependent pair
    set_id(1'b1, 3'd6, 3'd5, 2'b11, 3'd1, 1'b1, 1'b0); cyc();
    set_id(1'b1, 3'd1, 3'd1, 2'b11, 3'd2, 1'b1, 1'b0); cyc();
    set_id(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
    bus.mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_cycle();
      chk("ms_fwd_frozen", 32'(bus.fwd_sel), 32'b0101);
      chk("ms_stall", 32'(bus.id_stall), 32'd1);
      advance();
    end
    bus.mem_stall = 1'b0;
    check_cycle();
    chk("ms_resume_fwd", 32'(bus.fwd_sel), 32'b0101);
    advance();
    check_cycle();
    chk("ms_after_fwd", 32'(bus.fwd_sel), 32'd0);
    advance();
    idle(2);

    // Reset asserted while a load-use stall is pending
    set_id(1'b1, 3'd0, 3'd6, 2'b01, 3'd3, 1'b1, 1'b1); cyc();
    set_id(1'b1, 3'd0, 3'd3, 2'b11, 3'd4, 1'b1, 1'b0);
    #2;
    chk("pre_rst_stall", 32'(bus.id_stall), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_stall", 32'(bus.id_stall), 32'd0);
    chk("arst_bubble", 32'(bus.issue_bubble), 32'd0);
    chk("arst_exv", 32'(bus.ex_valid), 32'd0);
    chk("arst_fwd", 32'(bus.fwd_sel), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_cycle();
    chk("post_rst_accept", 32'(bus.id_stall), 32'd0);
    advance();
    check_cycle();
    chk("post_rst_exv", 32'(bus.ex_valid), 32'd1);
    advance();

    // Random traffic over a small register set; ID is held while it is stalled
    hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        set_id(1'($urandom_range(0, 99) < 85), lc3b_reg'($urandom_range(0, 3)),
               lc3b_reg'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               lc3b_reg'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 2) == 0));
      end
      bus.flush = 1'($urandom_range(0, 9) == 0);
      bus.mem_stall = 1'($urandom_range(0, 6) == 0);
      hold = bus.mem_stall || (m_hazard() && !bus.flush);
      cyc();
    end
    bus.flush = 1'b0;
    bus.mem_stall = 1'b0;

`ifdef HAZARD_STATS_EN
    bus.stats_clr = 1'b1;
    cyc();
    bus.stats_clr = 1'b0;
    check_cycle();
    chk("clr_stall_cnt", bus.stall_cnt, 32'd0);
    chk("clr_mstall_cnt", bus.mstall_cnt, 32'd0);
    advance();
`endif
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
